// File: rtl/bit_read_arbiter_rr_if.sv
// Bundle of the thread-side and RAM-side signals of the bit/word read arbiter.
// The slave modport is the arbiter; the master modport is the requester/RAM environment.
interface bit_read_arbiter_rr_if #(
  parameter int unsigned THREADS = 4,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 1
) ();

  localparam int unsigned ID_W = $clog2(THREADS);

  logic [THREADS-1:0]        thread_req;
  logic [THREADS*ADDR_W-1:0] thread_addr;
  logic [THREADS-1:0]        thread_ack;
  logic [DATA_W-1:0]         thread_data;
  logic                      ram_rd;
  logic [ADDR_W-1:0]         ram_addr;
  logic [DATA_W-1:0]         ram_data;
  logic                      busy;
  logic [ID_W-1:0]           grant_id;

  modport slave (
    input  thread_req, thread_addr, ram_data,
    output thread_ack, thread_data, ram_rd, ram_addr, busy, grant_id
  );

  modport master (
    output thread_req, thread_addr, ram_data,
    input  thread_ack, thread_data, ram_rd, ram_addr, busy, grant_id
  );

endinterface

// File: rtl/bit_read_arbiter_rr.sv
// Round-robin read arbiter between the PLC thread cores and the shared bit/word RAM read port.
// One read at a time: grant, issue one RAM read strobe, wait RAM_LAT cycles, pulse the
// granted thread's ACK with the returned data. Every output comes straight from a register.
module bit_read_arbiter_rr #(
  parameter int unsigned THREADS = 4,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 1,
  parameter int unsigned RAM_LAT = 1
) (
  input logic                  clk,
  input logic                  rst_n,
  bit_read_arbiter_rr_if.slave bus
);

  localparam int unsigned ID_W  = $clog2(THREADS);
  localparam int unsigned CNT_W = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StAck} state_e;

  state_e              state_q;
  logic [ID_W-1:0]     ptr_q;      // last thread served; search starts one above it
  logic [ID_W-1:0]     grant_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [ADDR_W-1:0]   ram_addr_q; // doubles as the latched grant address
  logic [DATA_W-1:0]   data_q;
  logic [THREADS-1:0]  ack_q;
  logic                ram_rd_q;
  logic                busy_q;

  logic                pick_valid;
  logic [ID_W-1:0]     pick_id;
  logic [ADDR_W-1:0]   pick_addr;

  // Round-robin pick: first requester at ptr+1, ptr+2, ... (mod THREADS). The loop runs from
  // the farthest distance down so the nearest requester is the last, winning, assignment.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    pick_addr  = '0;
    for (int unsigned i = THREADS; i > 0; i--) begin
      for (int unsigned t = 0; t < THREADS; t++) begin
        if (bus.thread_req[t] && (((32'(ptr_q) + i) % THREADS) == t)) begin
          pick_valid = 1'b1;
          pick_id    = ID_W'(t);
          pick_addr  = bus.thread_addr[t*ADDR_W +: ADDR_W];
        end
      end
    end
  end

  // Read sequencer: IDLE -> ISSUE -> WAIT (RAM_LAT cycles) -> ACK -> IDLE, outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      ptr_q      <= ID_W'(THREADS - 1);
      grant_q    <= '0;
      cnt_q      <= '0;
      ram_addr_q <= '0;
      data_q     <= '0;
      ack_q      <= '0;
      ram_rd_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (pick_valid) begin
            state_q    <= StIssue;
            grant_q    <= pick_id;
            ram_addr_q <= pick_addr;
            ram_rd_q   <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        StIssue: begin
          state_q    <= StWait;
          ram_rd_q   <= 1'b0;
          ram_addr_q <= '0;
          cnt_q      <= CNT_W'(RAM_LAT - 1);
        end
        StWait: begin
          if (cnt_q == '0) begin
            state_q <= StAck;
            data_q  <= bus.ram_data;
            ack_q   <= THREADS'(1) << grant_q;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StAck: begin
          state_q <= StIdle;
          ack_q   <= '0;
          data_q  <= '0;
          busy_q  <= 1'b0;
          ptr_q   <= grant_q;
          grant_q <= '0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.thread_ack  = ack_q;
  assign bus.thread_data = data_q;
  assign bus.ram_rd      = ram_rd_q;
  assign bus.ram_addr    = ram_addr_q;
  assign bus.busy        = busy_q;
  assign bus.grant_id    = grant_q;

endmodule

// File: tb/tb_bit_read_arbiter_rr.sv
// Bench for bit_read_arbiter_rr: table-driven single reads on a bit-wide (RAM_LAT=1) and a
// word-wide (RAM_LAT=2) instance, then directed and random traffic on a RAM_LAT=3 instance
// checked every cycle against a transaction-timeline reference model.
module tb_bit_read_arbiter_rr;

  localparam int T     = 4;
  localparam int AW    = 16;
  localparam int LAT_A = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bit_read_arbiter_rr_if #(.THREADS(T), .ADDR_W(AW), .DATA_W(16)) if_a ();
  bit_read_arbiter_rr_if #(.THREADS(T), .ADDR_W(AW), .DATA_W(1))  if_b ();
  bit_read_arbiter_rr_if #(.THREADS(T), .ADDR_W(AW), .DATA_W(16)) if_c ();

  bit_read_arbiter_rr #(.THREADS(T), .ADDR_W(AW), .DATA_W(16), .RAM_LAT(LAT_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(if_a));
  bit_read_arbiter_rr #(.THREADS(T), .ADDR_W(AW), .DATA_W(1), .RAM_LAT(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(if_b));
  bit_read_arbiter_rr #(.THREADS(T), .ADDR_W(AW), .DATA_W(16), .RAM_LAT(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .bus(if_c));

  int n_tests = 0;
  int n_fail  = 0;
  int n_cyc   = 0;

  // ---------------- RAM model for instance A: data valid LAT_A cycles after the strobe
  function automatic logic [15:0] ram_f(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  logic        rp_v [LAT_A];
  logic [15:0] rp_a [LAT_A];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < LAT_A; k++) begin
        rp_v[k] <= 1'b0;
        rp_a[k] <= '0;
      end
    end else begin
      rp_v[0] <= if_a.ram_rd;
      rp_a[0] <= if_a.ram_addr;
      for (int k = 1; k < LAT_A; k++) begin
        rp_v[k] <= rp_v[k-1];
        rp_a[k] <= rp_a[k-1];
      end
    end
  end

  always_comb if_a.ram_data = rp_v[LAT_A-1] ? ram_f(rp_a[LAT_A-1]) : 16'hDEAD;

  // ---------------- Reference model: one transaction timeline, phase 1 = strobe cycle
  bit          m_active;
  int          m_phase;
  int          m_id;
  logic [15:0] m_addr;
  int          m_ptr;

  task automatic model_reset();
    m_active = 1'b0;
    m_phase  = 0;
    m_id     = 0;
    m_addr   = '0;
    m_ptr    = T - 1;
  endtask

  task automatic model_step();
    logic [3:0]  rq;
    logic [63:0] ad;
    bit          found;
    int          c;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (m_active) begin
      m_phase++;
      if (m_phase == LAT_A + 3) begin
        m_active = 1'b0;
        m_ptr    = m_id;
      end
    end else if (if_a.thread_req != '0) begin
      found = 1'b0;
      for (int k = 1; k <= T && !found; k++) begin
        c  = (m_ptr + k) % T;
        rq = if_a.thread_req >> c;
        if (rq[0]) begin
          m_id  = c;
          found = 1'b1;
        end
      end
      ad       = if_a.thread_addr >> (m_id * AW);
      m_addr   = ad[15:0];
      m_active = 1'b1;
      m_phase  = 1;
    end
  endtask

  function automatic bit model_ack(input int t);
    return m_active && (m_phase == LAT_A + 2) && (m_id == t);
  endfunction

  // ---------------- Checking helpers
  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  int ack_id_q[$];
  int ack_cyc_q[$];

  task automatic check_a(input string name);
    logic [3:0]  e_ack;
    logic [15:0] e_data, e_addr;
    logic        e_rd, e_busy;
    logic [1:0]  e_gid;
    e_busy = m_active;
    e_gid  = m_active ? 2'(m_id) : 2'd0;
    e_rd   = m_active && (m_phase == 1);
    e_addr = e_rd ? m_addr : 16'h0;
    e_ack  = (m_active && m_phase == LAT_A + 2) ? (4'b0001 << m_id) : 4'b0000;
    e_data = (e_ack != 4'b0000) ? ram_f(m_addr) : 16'h0;
    cmp($sformatf("%s cyc%0d {ack,data,rd,addr,busy,gid}", name, n_cyc),
        {24'b0, if_a.thread_ack, if_a.thread_data, if_a.ram_rd, if_a.ram_addr, if_a.busy,
         if_a.grant_id},
        {24'b0, e_ack, e_data, e_rd, e_addr, e_busy, e_gid});
    for (int t = 0; t < T; t++) begin
      if (if_a.thread_ack[t]) begin
        ack_id_q.push_back(t);
        ack_cyc_q.push_back(n_cyc);
      end
    end
  endtask

  task automatic tick_a(input string name);
    @(posedge clk);
    model_step();
    n_cyc++;
    @(negedge clk);
    check_a(name);
  endtask

  task automatic set_addr(input int t, input logic [15:0] a);
    if_a.thread_addr[t*AW +: AW] = a;
  endtask

  task automatic drop_acked();
    for (int t = 0; t < T; t++) if (model_ack(t)) if_a.thread_req[t] = 1'b0;
  endtask

  task automatic clear_log();
    ack_id_q.delete();
    ack_cyc_q.delete();
  endtask

  task automatic expect_order(input string name, input int exp_ids[$]);
    int got;
    for (int k = 0; k < exp_ids.size(); k++) begin
      got = (k < ack_id_q.size()) ? ack_id_q[k] : -1;
      cmp($sformatf("%s ack#%0d thread", name, k), 64'(got), 64'(exp_ids[k]));
    end
  endtask

  task automatic run_until_acks(input string name, input int n, input int budget);
    for (int c = 0; c < budget && ack_id_q.size() < n; c++) begin
      tick_a(name);
      drop_acked();
    end
    if (ack_id_q.size() < n) cmp({name, " ack count (timeout)"}, 64'(ack_id_q.size()), 64'(n));
  endtask

  task automatic run_until_idle(input string name);
    for (int c = 0; c < 20 && m_active; c++) tick_a(name);
  endtask

  task automatic run_until_wait(input string name);
    for (int c = 0; c < 20 && !(m_active && m_phase == 2); c++) tick_a(name);
  endtask

  // ---------------- Vector tables for the small instances
  typedef struct packed {
    logic [3:0]  req;
    logic [1:0]  tid;
    logic [15:0] addr;
    logic [15:0] rdata;
    logic [3:0]  e_ack;
    logic [15:0] e_data;
    logic        e_rd;
    logic [15:0] e_addr;
    logic        e_busy;
    logic [1:0]  e_gid;
  } vec_t;

  vec_t vb[9];
  vec_t vc[6];
  int   ex[$];

  initial begin
    rst_n = 1'b0;
    model_reset();
    if_a.thread_req = '0; if_a.thread_addr = '0;
    if_b.thread_req = '0; if_b.thread_addr = '0; if_b.ram_data = '0;
    if_c.thread_req = '0; if_c.thread_addr = '0; if_c.ram_data = '0;

    // bit access, RAM_LAT=1: thread 0 reads 1, then thread 1 reads 0
    vb[0] = '{4'b0001, 2'd0, 16'h0123, 16'h0, 4'b0000, 16'h0, 1'b0, 16'h0000, 1'b0, 2'd0};
    vb[1] = '{4'b0001, 2'd0, 16'h0123, 16'h0, 4'b0000, 16'h0, 1'b1, 16'h0123, 1'b1, 2'd0};
    vb[2] = '{4'b0001, 2'd0, 16'h0123, 16'h1, 4'b0000, 16'h0, 1'b0, 16'h0000, 1'b1, 2'd0};
    vb[3] = '{4'b0000, 2'd0, 16'h0123, 16'h0, 4'b0001, 16'h1, 1'b0, 16'h0000, 1'b1, 2'd0};
    vb[4] = '{4'b0010, 2'd1, 16'hFFFF, 16'h1, 4'b0000, 16'h0, 1'b0, 16'h0000, 1'b0, 2'd0};
    vb[5] = '{4'b0010, 2'd1, 16'hFFFF, 16'h1, 4'b0000, 16'h0, 1'b1, 16'hFFFF, 1'b1, 2'd1};
    vb[6] = '{4'b0010, 2'd1, 16'hFFFF, 16'h0, 4'b0000, 16'h0, 1'b0, 16'h0000, 1'b1, 2'd1};
    vb[7] = '{4'b0000, 2'd1, 16'hFFFF, 16'h1, 4'b0010, 16'h0, 1'b0, 16'h0000, 1'b1, 2'd1};
    vb[8] = '{4'b0000, 2'd1, 16'hFFFF, 16'h1, 4'b0000, 16'h0, 1'b0, 16'h0000, 1'b0, 2'd0};
    // word access, RAM_LAT=2: data only in the ACK cycle, RAM garbage around it
    vc[0] = '{4'b0100, 2'd2, 16'h0ABC, 16'h0000, 4'b0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 2'd0};
    vc[1] = '{4'b0100, 2'd2, 16'h0ABC, 16'h1234, 4'b0000, 16'h0000, 1'b1, 16'h0ABC, 1'b1, 2'd2};
    vc[2] = '{4'b0100, 2'd2, 16'h0ABC, 16'h1234, 4'b0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 2'd2};
    vc[3] = '{4'b0100, 2'd2, 16'h0ABC, 16'hBEEF, 4'b0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 2'd2};
    vc[4] = '{4'b0000, 2'd2, 16'h0ABC, 16'h5555, 4'b0100, 16'hBEEF, 1'b0, 16'h0000, 1'b1, 2'd2};
    vc[5] = '{4'b0000, 2'd2, 16'h0ABC, 16'hBEEF, 4'b0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 2'd0};

    repeat (2) @(negedge clk);
    check_a("reset");
    rst_n = 1'b1;

    for (int k = 0; k < 9; k++) begin
      if_b.thread_req = vb[k].req;
      if_b.thread_addr[vb[k].tid*AW +: AW] = vb[k].addr;
      if_b.ram_data = vb[k].rdata[0];
      cmp($sformatf("bit_read row%0d", k),
          {24'b0, if_b.thread_ack, 15'b0, if_b.thread_data, if_b.ram_rd, if_b.ram_addr,
           if_b.busy, if_b.grant_id},
          {24'b0, vb[k].e_ack, 15'b0, vb[k].e_data[0], vb[k].e_rd, vb[k].e_addr,
           vb[k].e_busy, vb[k].e_gid});
      @(negedge clk);
    end
    for (int k = 0; k < 6; k++) begin
      if_c.thread_req = vc[k].req;
      if_c.thread_addr[vc[k].tid*AW +: AW] = vc[k].addr;
      if_c.ram_data = vc[k].rdata;
      cmp($sformatf("word_read row%0d", k),
          {24'b0, if_c.thread_ack, if_c.thread_data, if_c.ram_rd, if_c.ram_addr, if_c.busy,
           if_c.grant_id},
          {24'b0, vc[k].e_ack, vc[k].e_data, vc[k].e_rd, vc[k].e_addr, vc[k].e_busy,
           vc[k].e_gid});
      @(negedge clk);
    end

    // fairness: all four hold REQ, each drops on its ACK and re-raises a cycle later
    clear_log();
    for (int t = 0; t < T; t++) set_addr(t, 16'(16'h1000 + t));
    if_a.thread_req = 4'b1111;
    for (int c = 0; c < 80 && ack_id_q.size() < 6; c++) begin
      tick_a("fair");
      for (int t = 0; t < T; t++) begin
        if (model_ack(t)) if_a.thread_req[t] = 1'b0;
        else if (!if_a.thread_req[t]) if_a.thread_req[t] = 1'b1;
      end
    end
    ex = {0, 1, 2, 3, 0, 1};
    expect_order("fair", ex);
    for (int k = 1; k < 6; k++) begin
      if (k < ack_cyc_q.size())
        cmp($sformatf("fair ack spacing #%0d", k), 64'(ack_cyc_q[k] - ack_cyc_q[k-1]), 64'd6);
    end
    if_a.thread_req = '0;
    run_until_idle("fair_drain");

    // asynchronous reset in the middle of WAIT
    clear_log();
    set_addr(2, 16'h2222);
    if_a.thread_req = 4'b0100;
    run_until_wait("rst_pre");
    #2 rst_n = 1'b0;
    model_reset();
    #1 cmp("async reset outputs",
           {24'b0, if_a.thread_ack, if_a.thread_data, if_a.ram_rd, if_a.ram_addr, if_a.busy,
            if_a.grant_id}, 64'd0);
    tick_a("in_rst");
    tick_a("in_rst");
    rst_n = 1'b1;
    set_addr(0, 16'h0A0A);
    if_a.thread_req = 4'b0101;
    run_until_acks("post_rst", 2, 30);
    ex = {0, 2};
    expect_order("post_rst", ex);
    run_until_idle("post_rst_drain");

    // granted thread abandons during WAIT while thread 1 raises a request
    clear_log();
    set_addr(2, 16'h4444);
    if_a.thread_req = 4'b0100;
    run_until_wait("abandon_pre");
    if_a.thread_req[2] = 1'b0;
    if_a.thread_req[1] = 1'b1;
    set_addr(1, 16'h1111);
    set_addr(2, 16'h9999);
    run_until_acks("abandon", 2, 30);
    ex = {2, 1};
    expect_order("abandon", ex);
    run_until_idle("abandon_drain");

    // pointer at 3 after serving thread 3; 0 and 3 both request in the following IDLE
    clear_log();
    set_addr(3, 16'h3333);
    if_a.thread_req = 4'b1000;
    for (int c = 0; c < 20 && !model_ack(3); c++) tick_a("wrap_pre");
    if_a.thread_req[0] = 1'b1;
    set_addr(0, 16'h0F0F);
    run_until_acks("wrap", 3, 40);
    ex = {3, 0, 3};
    expect_order("wrap", ex);
    run_until_idle("wrap_drain");

    // random traffic obeying the requester protocol, with occasional abandons
    if_a.thread_req = '0;
    for (int c = 0; c < 3000; c++) begin
      tick_a("rand");
      for (int t = 0; t < T; t++) begin
        if (model_ack(t)) begin
          if ($urandom_range(3) != 0) if_a.thread_req[t] = 1'b0;
        end else if (!if_a.thread_req[t]) begin
          set_addr(t, 16'($urandom));
          if ($urandom_range(2) == 0) if_a.thread_req[t] = 1'b1;
        end else if (m_active && m_id == t && $urandom_range(15) == 0) begin
          if_a.thread_req[t] = 1'b0;
          set_addr(t, 16'($urandom));
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
